// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of one single-ported 16-bit word memory.
// Data has fixed priority and a wait counter keeps fetch from starving.
// A dump request takes one idle memory cycle of its own.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_req/if_addr      fetch read request (held until if_gnt)
//   if_gnt              fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata  fetch read data, one cycle after the grant
//   d_req/d_wr/d_addr   data request (held until d_gnt), 1 = write
//   d_wdata             data write data
//   d_gnt               data accepted this cycle (combinational)
//   d_rvalid/d_rdata    data read data, one cycle after a read grant
//   dump_req            one-cycle pulse asking for a memory dump
//   dump_done           pulses in the cycle after the dump cycle
//   mem_*               drive of the memory instance
//   mem_rdata           combinational read data from the memory
//   conflict_cnt        saturating count of cycles with both requests up
module mem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [15:0]      if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [15:0]      if_rdata,
  input  logic             d_req,
  input  logic             d_wr,
  input  logic [15:0]      d_addr,
  input  logic [15:0]      d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [15:0]      d_rdata,
  input  logic             dump_req,
  output logic             dump_done,
  output logic             mem_en,
  output logic             mem_wr,
  output logic [15:0]      mem_addr,
  output logic [15:0]      mem_wdata,
  output logic             mem_dump,
  input  logic [15:0]      mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [3:0]       WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [3:0]       WAIT_ONE = 4'd1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  logic [3:0]       r_wait_cnt;
  logic             r_dump_pending;
  logic             r_dump_done;
  logic             r_if_rvalid;
  logic             r_d_rvalid;
  logic [15:0]      r_if_rdata;
  logic [15:0]      r_d_rdata;
  logic [CNT_W-1:0] r_conflict_cnt;

  logic w_dump;
  logic w_if_starved;
  logic w_if_gnt;
  logic w_d_gnt;
  logic w_conflict;

  // Nothing reaches the memory while rst is high so its
  // reset-time load is left alone.
  assign w_dump       = ~rst & r_dump_pending;
  assign w_if_starved = (r_wait_cnt == WAIT_MAX);
  assign w_conflict   = if_req & d_req;

  // The conditions overlap, so this is a priority chain.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (rst || r_dump_pending) begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end else if (if_req && w_if_starved) begin
      w_if_gnt = 1'b1;
    end else if (d_req) begin
      w_d_gnt = 1'b1;
    end else if (if_req) begin
      w_if_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    if (w_d_gnt) begin
      mem_en    = 1'b1;
      mem_wr    = d_wr;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  assign mem_dump = w_dump;
  assign if_gnt   = w_if_gnt;
  assign d_gnt    = w_d_gnt;

  // A pending dump absorbs further pulses and clears in its own cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dump_pending <= 1'b0;
      r_dump_done    <= 1'b0;
    end else begin
      r_dump_pending <= r_dump_pending ? 1'b0 : dump_req;
      r_dump_done    <= r_dump_pending;
    end
  end

  // Counts denied fetch cycles, dump cycles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
    end else if (if_req && !w_if_gnt) begin
      if (!w_if_starved) begin
        r_wait_cnt <= r_wait_cnt + WAIT_ONE;
      end
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && r_conflict_cnt != CNT_SAT) begin
      r_conflict_cnt <= r_conflict_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= 16'h0000;
    end else begin
      r_if_rvalid <= w_if_gnt;
      if (w_if_gnt) begin
        r_if_rdata <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_rvalid <= 1'b0;
      r_d_rdata  <= 16'h0000;
    end else begin
      r_d_rvalid <= w_d_gnt & ~d_wr;
      if (w_d_gnt && !d_wr) begin
        r_d_rdata <= mem_rdata;
      end
    end
  end

  // A read granted just before rst rises must not report valid data.
  assign if_rvalid    = r_if_rvalid & ~rst;
  assign d_rvalid     = r_d_rvalid & ~rst;
  assign dump_done    = r_dump_done & ~rst;
  assign if_rdata     = r_if_rdata;
  assign d_rdata      = r_d_rdata;
  assign conflict_cnt = r_conflict_cnt;

endmodule
